// File: rtl/lsp_get_quant.sv
// G.729 LSP decoder: rebuilds quantized LSPs from (mode, L1, L2, L3) indices,
// applies two-pass gap expansion, MA-predicts into lspq and shifts freq_prev.
module lsp_get_quant #(
  parameter int               M              = 10,
  parameter int               MA_NP          = 4,
  parameter int               NC             = 5,
  parameter logic signed [15:0] GAP1         = 16'sd10,
  parameter logic signed [15:0] GAP2         = 16'sd5,
  parameter logic [11:0]      LSPCB1_BASE    = 12'h000,
  parameter logic [11:0]      LSPCB2_BASE    = 12'h500,
  parameter logic [11:0]      FG_BASE        = 12'h640,
  parameter logic [11:0]      FG_SUM_BASE    = 12'h690,
  parameter logic [11:0]      FREQ_PREV_BASE = 12'h100,
  parameter logic [11:0]      LSPQ_BASE      = 12'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [6:0]  code0,
  input  logic [4:0]  code1,
  input  logic [4:0]  code2,
  output logic        done,
  output logic [11:0] readAddr,
  input  logic [31:0] readIn,
  output logic [11:0] writeAddr,
  output logic [31:0] writeOut,
  output logic        writeEn,
  output logic [11:0] const_addr,
  input  logic [31:0] const_in
);

  // COMPOSE: phase 0 fg_sum, 1..MA_NP fg/freq_prev, MA_NP+1 last mac, then write
  localparam int CPH_LAST = MA_NP + 2;
  localparam int UPH_LAST = MA_NP;

  typedef enum logic [2:0] {S_IDLE, S_CB, S_EXP1, S_EXP2, S_COMP, S_UPD, S_DONE} state_t;

  state_t             r_state, w_nstate;
  logic [4:0]         r_cnt;
  logic [3:0]         r_j;
  logic               r_mode;
  logic [6:0]         r_code0;
  logic [4:0]         r_code1, r_code2;
  logic signed [15:0] r_buf [M];
  logic signed [15:0] r_tmp;
  logic signed [31:0] r_acc;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] s);
    if (s[16] != s[15]) return s[16] ? 16'sh8000 : 16'sh7fff;
    return s[15:0];
  endfunction

  function automatic logic signed [15:0] add16(input logic signed [15:0] a, input logic signed [15:0] b);
    return sat16(17'(a) + 17'(b));
  endfunction

  function automatic logic signed [15:0] sub16(input logic signed [15:0] a, input logic signed [15:0] b);
    return sat16(17'(a) - 17'(b));
  endfunction

  function automatic logic signed [31:0] l_mult(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    if (p == 32'sh4000_0000) return 32'sh7fff_ffff;
    return p <<< 1;
  endfunction

  function automatic logic signed [31:0] l_add(input logic signed [31:0] a, input logic signed [31:0] b);
    logic signed [32:0] s;
    s = 33'(a) + 33'(b);
    if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
    return s[31:0];
  endfunction

  function automatic logic [11:0] row_addr(input logic [11:0] base, input logic [11:0] row,
                                           input logic [11:0] col);
    return base + row * 12'(M) + col;
  endfunction

  logic [3:0]         w_el, w_cb_el, w_ja;
  logic [4:0]         w_cbm1;
  logic [11:0]        w_j12, w_k12;
  logic signed [15:0] w_prev, w_cur, w_gap, w_diff, w_shift;
  logic               w_unused;

  assign w_el     = r_cnt[4:1];
  assign w_cbm1   = r_cnt - 5'd1;
  assign w_cb_el  = w_cbm1[4:1];
  assign w_j12    = {8'd0, r_j};
  assign w_k12    = 12'(r_cnt) - 12'd1;
  assign w_ja     = r_cnt[3:0];
  assign w_prev   = r_buf[w_ja - 4'd1];
  assign w_cur    = r_buf[w_ja];
  assign w_gap    = (r_state == S_EXP1) ? GAP1 : GAP2;
  assign w_diff   = sub16(add16(w_prev, w_gap), w_cur);
  assign w_shift  = w_diff >>> 1;
  assign w_unused = ^{const_in[31:16], readIn[31:16]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  always_comb begin
    w_nstate   = r_state;
    done       = 1'b0;
    readAddr   = '0;
    writeAddr  = '0;
    writeOut   = '0;
    writeEn    = 1'b0;
    const_addr = '0;
    case (r_state)
      S_IDLE: if (start) w_nstate = S_CB;
      S_CB: begin
        // even count fetches lspcb1, odd count lspcb2 for the same element
        if (r_cnt < 5'(2 * M))
          const_addr = r_cnt[0]
            ? row_addr(LSPCB2_BASE, {7'd0, (int'(w_el) < NC) ? r_code1 : r_code2}, {8'd0, w_el})
            : row_addr(LSPCB1_BASE, {5'd0, r_code0}, {8'd0, w_el});
        else
          w_nstate = S_EXP1;
      end
      S_EXP1: if (r_cnt == 5'(M - 1)) w_nstate = S_EXP2;
      S_EXP2: if (r_cnt == 5'(M - 1)) w_nstate = S_COMP;
      S_COMP: begin
        if (r_cnt == 5'd0)
          const_addr = row_addr(FG_SUM_BASE, {11'd0, r_mode}, w_j12);
        if (r_cnt >= 5'd1 && r_cnt <= 5'(MA_NP)) begin
          const_addr = row_addr(FG_BASE + (r_mode ? 12'(MA_NP * M) : 12'd0), w_k12, w_j12);
          readAddr   = row_addr(FREQ_PREV_BASE, w_k12, w_j12);
        end
        if (r_cnt == 5'(CPH_LAST)) begin
          writeEn   = 1'b1;
          writeAddr = LSPQ_BASE + w_j12;
          writeOut  = {{16{r_acc[31]}}, r_acc[31:16]};
          if (r_j == 4'(M - 1)) w_nstate = S_UPD;
        end
      end
      S_UPD: begin
        // read k-1 one cycle ahead of writing k, walking k downward
        if (r_cnt < 5'(MA_NP - 1))
          readAddr = row_addr(FREQ_PREV_BASE, 12'(MA_NP - 2) - 12'(r_cnt), w_j12);
        if (r_cnt >= 5'd1 && r_cnt < 5'(MA_NP)) begin
          writeEn   = 1'b1;
          writeAddr = row_addr(FREQ_PREV_BASE, 12'(MA_NP) - 12'(r_cnt), w_j12);
          writeOut  = {{16{readIn[15]}}, readIn[15:0]};
        end
        if (r_cnt == 5'(UPH_LAST)) begin
          writeEn   = 1'b1;
          writeAddr = row_addr(FREQ_PREV_BASE, 12'd0, w_j12);
          writeOut  = {{16{r_buf[r_j][15]}}, r_buf[r_j]};
          if (r_j == 4'(M - 1)) w_nstate = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_j     <= '0;
      r_mode  <= 1'b0;
      r_code0 <= '0;
      r_code1 <= '0;
      r_code2 <= '0;
      r_tmp   <= '0;
      r_acc   <= '0;
      for (int i = 0; i < M; i++) r_buf[i] <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_mode  <= mode;
        r_code0 <= code0;
        r_code1 <= code1;
        r_code2 <= code2;
      end
      if (w_nstate != r_state) begin
        r_cnt <= (w_nstate == S_EXP1 || w_nstate == S_EXP2) ? 5'd1 : 5'd0;
        r_j   <= '0;
      end else if ((r_state == S_COMP && r_cnt == 5'(CPH_LAST)) ||
                   (r_state == S_UPD  && r_cnt == 5'(UPH_LAST))) begin
        r_cnt <= '0;
        r_j   <= r_j + 4'd1;
      end else if (r_state != S_IDLE) begin
        r_cnt <= r_cnt + 5'd1;
      end
      case (r_state)
        S_CB: if (r_cnt != 5'd0) begin
          if (!w_cbm1[0]) r_tmp <= const_in[15:0];
          else            r_buf[w_cb_el] <= add16(r_tmp, const_in[15:0]);
        end
        S_EXP1, S_EXP2: if (w_shift > 16'sd0) begin
          r_buf[w_ja - 4'd1] <= sub16(w_prev, w_shift);
          r_buf[w_ja]        <= add16(w_cur, w_shift);
        end
        S_COMP: begin
          if (r_cnt == 5'd1)
            r_acc <= l_mult(r_buf[r_j], const_in[15:0]);
          else if (r_cnt >= 5'd2 && r_cnt <= 5'(MA_NP + 1))
            r_acc <= l_add(r_acc, l_mult(const_in[15:0], readIn[15:0]));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_get_quant.sv
// Directed bench for lsp_get_quant: behavioural scratch/constant memories and
// hand-computed expectations for codebook sum, expansion, MA compose and history.
module tb_lsp_get_quant;
  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [6:0]  code0;
  logic [4:0]  code1, code2;
  logic        done, writeEn;
  logic [11:0] readAddr, writeAddr, const_addr;
  logic [31:0] readIn, writeOut, const_in;

  logic [31:0] cmem [4096];
  logic [31:0] smem [4096];
  logic        tb_we;
  logic [11:0] tb_wa;
  logic [31:0] tb_wd;

  int n_chk = 0, n_fail = 0, n_done = 0, n_clash = 0, ref_lat = -1;

  always #5 clk = ~clk;

  lsp_get_quant dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .code0(code0), .code1(code1), .code2(code2), .done(done),
    .readAddr(readAddr), .readIn(readIn), .writeAddr(writeAddr),
    .writeOut(writeOut), .writeEn(writeEn), .const_addr(const_addr),
    .const_in(const_in)
  );

  always @(posedge clk) begin
    const_in <= cmem[const_addr];
    readIn   <= smem[readAddr];
    if (writeEn)    smem[writeAddr] <= writeOut;
    else if (tb_we) smem[tb_wa] <= tb_wd;
  end

  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (writeEn === 1'b1 && readAddr == writeAddr) n_clash++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, $signed(act), $signed(exp));
    end
  endtask

  task automatic clr_cmem();
    for (int i = 0; i < 4096; i++) cmem[i] = 32'h0;
  endtask

  // upper half filled with junk: only the low 16 bits may be used
  task automatic cset(input int a, input int v);
    cmem[a] = {16'hA5A5, 16'(v)};
  endtask

  task automatic load_t1();
    clr_cmem();
    for (int j = 0; j < 10; j++) begin
      cset(j, 1000 * (j + 1));
      cset(10 + j, 7000);
      cset('h690 + j, 16384);
    end
  endtask

  task automatic load_t5();
    clr_cmem();
    for (int j = 0; j < 10; j++) begin
      cset(j, 1000 * (j + 1));
      cset('h690 + j, 16384);
      for (int r = 0; r < 32; r++) cset('h500 + r * 10 + j, 10 * r);
    end
  endtask

  task automatic preload_fp(input bit pattern);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 10; j++) begin
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = 12'(256 + k * 10 + j);
        tb_wd = pattern ? 32'(100 * k + j) : 32'h0;
      end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  function automatic logic [31:0] lspq(input int j);
    return smem[320 + j];
  endfunction

  function automatic logic [31:0] fp(input int k, input int j);
    return smem[256 + k * 10 + j];
  endfunction

  task automatic run(input logic m, input logic [6:0] c0, input logic [4:0] c1,
                     input logic [4:0] c2, input int poke, input string tag);
    int lat, d0;
    d0 = n_done;
    @(negedge clk);
    mode = m; code0 = c0; code1 = c1; code2 = c2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 2000) begin
      if (lat == poke) begin start = 1'b1; code0 = 7'd1; mode = ~m; end
      else begin start = 1'b0; code0 = c0; mode = m; end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (done !== 1'b1)  chk({tag, "_timeout"}, 0, 1);
    else if (ref_lat < 0) ref_lat = lat;
    else chk({tag, "_latency"}, lat, ref_lat);
    repeat (3) @(negedge clk);
    chk({tag, "_done_count"}, n_done - d0, 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    code0 = '0; code1 = '0; code2 = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    clr_cmem();
    #12;
    chk("rst_done", done, 0);
    chk("rst_const_addr", const_addr, 0);
    chk("rst_writeEn", writeEn, 0);
    chk("rst_readAddr", readAddr, 0);
    @(negedge clk) reset = 1'b1;

    // 1: plain codebook, fg_sum = 0.5
    load_t1();
    preload_fp(1'b0);
    run(1'b0, 7'd0, 5'd0, 5'd0, 0, "t1");
    chk("t1_lspq0", lspq(0), 500);
    chk("t1_lspq4", lspq(4), 2500);
    chk("t1_lspq9", lspq(9), 5000);
    chk("t1_fp0_9", fp(0, 9), 10000);

    // 2: close pair expanded by EXP1 only
    clr_cmem();
    cset(0, 1000); cset(1, 1004);
    for (int j = 2; j < 10; j++) cset(j, 1004 + 2000 * (j - 1));
    for (int j = 0; j < 10; j++) cset('h690 + j, 16384);
    run(1'b0, 7'd0, 5'd0, 5'd0, 0, "t2");
    chk("t2_fp0_0", fp(0, 0), 997);
    chk("t2_fp0_1", fp(0, 1), 1007);
    chk("t2_fp0_2", fp(0, 2), 3004);
    chk("t2_fp1_0", fp(1, 0), 1000);
    chk("t2_lspq0", lspq(0), 498);
    chk("t2_lspq1", lspq(1), 503);

    // 3: saturation, mode 1, nonzero row indices, decoy mode-0 tables
    clr_cmem();
    for (int j = 0; j < 10; j++) begin
      cset(50 + j, 32000);
      cset('h500 + 20 + j, 2000);
      cset('h690 + 10 + j, 32767);
      cset('h690 + j, 100);
      for (int k = 0; k < 4; k++) cset('h640 + k * 10 + j, 1000);
    end
    run(1'b1, 7'd5, 5'd2, 5'd2, 0, "t3");
    chk("t3_lspq0", lspq(0), 32766);
    chk("t3_lspq9", lspq(9), 32766);
    chk("t3_fp0_4", fp(0, 4), 32767);

    // 4: history shift plus one active MA tap (fg[0][1] = 0.5)
    preload_fp(1'b1);
    load_t1();
    for (int j = 0; j < 10; j++) cset('h640 + 10 + j, 16384);
    run(1'b0, 7'd0, 5'd0, 5'd0, 0, "t4");
    chk("t4_lspq0", lspq(0), 550);
    chk("t4_lspq1", lspq(1), 1050);
    chk("t4_lspq9", lspq(9), 5054);
    chk("t4_fp3_0", fp(3, 0), 200);
    chk("t4_fp3_9", fp(3, 9), 209);
    chk("t4_fp2_5", fp(2, 5), 105);
    chk("t4_fp1_0", fp(1, 0), 0);
    chk("t4_fp1_9", fp(1, 9), 9);
    chk("t4_fp0_3", fp(0, 3), 4000);

    // 5: split halves use different lspcb2 rows
    load_t5();
    run(1'b0, 7'd0, 5'd3, 5'd7, 0, "t5");
    chk("t5_lspq0", lspq(0), 515);
    chk("t5_lspq4", lspq(4), 2515);
    chk("t5_lspq5", lspq(5), 3035);
    chk("t5_lspq9", lspq(9), 5035);
    chk("t5_fp0_4", fp(0, 4), 5030);
    chk("t5_fp0_5", fp(0, 5), 6070);

    // 6a: start pulsed mid-COMPOSE with different codes is ignored
    load_t1();
    run(1'b0, 7'd0, 5'd0, 5'd0, 50, "t6a");
    chk("t6a_lspq0", lspq(0), 500);
    chk("t6a_lspq9", lspq(9), 5000);

    // 6b: reset during EXP1, then a fresh decode
    load_t5();
    @(negedge clk);
    mode = 1'b0; code0 = '0; code1 = 5'd3; code2 = 5'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (24) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6b_rst_done", done, 0);
    chk("t6b_rst_writeEn", writeEn, 0);
    chk("t6b_rst_const_addr", const_addr, 0);
    chk("t6b_rst_writeOut", writeOut, 0);
    begin
      int d0;
      d0 = n_done;
      @(negedge clk) reset = 1'b1;
      repeat (200) @(negedge clk);
      chk("t6b_idle_no_done", n_done - d0, 0);
    end
    run(1'b0, 7'd0, 5'd3, 5'd7, 0, "t6b");
    chk("t6b_lspq0", lspq(0), 515);
    chk("t6b_lspq9", lspq(9), 5035);

    chk("rw_same_addr", n_clash, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_chk);
    $fatal(1);
  end

endmodule
